// File: rtl/writeback_arbiter.sv
// Writeback arbiter: merges X/Y execute results into one in-order register-file write per cycle.
// Small circular queue absorbs bursts; issue is stalled early enough that in-flight Y ops fit.
module writeback_arbiter #(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned STALL_TH = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [4:0]  x_wb_regdest,
  input  logic        x_wb_writereg,
  input  logic [31:0] x_wb_wbvalue,
  input  logic [4:0]  y_wb_regdest,
  input  logic        y_wb_writereg,
  input  logic [31:0] y_wb_wbvalue,
  output logic [4:0]  wb_rf_regdest,
  output logic        wb_rf_writereg,
  output logic [31:0] wb_rf_wbvalue,
  output logic        wb_is_stall,
  output logic        wb_overflow,
  output logic [3:0]  wb_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [4:0]       r_mem_dest [DEPTH];
  logic [31:0]      r_mem_val  [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [3:0]       r_count;
  logic             r_overflow;
  logic             r_rf_writereg;
  logic [4:0]       r_rf_regdest;
  logic [31:0]      r_rf_wbvalue;

  logic             w_x_acc;
  logic             w_y_acc;
  logic             w_pop;
  logic             w_enq_y;
  logic             w_enq_x;
  logic             w_drop;
  logic [PTR_W-1:0] w_x_ptr;
  logic [3:0]       w_count_next;
  logic             w_out_valid;
  logic [4:0]       w_out_dest;
  logic [31:0]      w_out_val;

  // r0 writes are architecturally meaningless, so they never occupy a slot.
  assign w_x_acc = x_wb_writereg && (x_wb_regdest != 5'd0);
  assign w_y_acc = y_wb_writereg && (y_wb_regdest != 5'd0);

  assign w_pop = (r_count != 4'd0);

  // Only a full queue with both inputs can exceed capacity; the newest (X) loses.
  assign w_drop  = (r_count == 4'(DEPTH)) && w_x_acc && w_y_acc;
  assign w_enq_y = w_y_acc && w_pop;
  assign w_enq_x = w_x_acc && (w_pop || w_y_acc) && !w_drop;
  assign w_x_ptr = r_wr_ptr + PTR_W'(w_enq_y);

  assign w_count_next = r_count + {3'b000, w_enq_y} + {3'b000, w_enq_x} - {3'b000, w_pop};

  // Head of the logical sequence: queue, then Y, then X.
  always_comb begin
    w_out_valid = 1'b0;
    w_out_dest  = r_rf_regdest;
    w_out_val   = r_rf_wbvalue;
    if (w_pop) begin
      w_out_valid = 1'b1;
      w_out_dest  = r_mem_dest[r_rd_ptr];
      w_out_val   = r_mem_val[r_rd_ptr];
    end else if (w_y_acc) begin
      w_out_valid = 1'b1;
      w_out_dest  = y_wb_regdest;
      w_out_val   = y_wb_wbvalue;
    end else if (w_x_acc) begin
      w_out_valid = 1'b1;
      w_out_dest  = x_wb_regdest;
      w_out_val   = x_wb_wbvalue;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
      r_count       <= 4'd0;
      r_overflow    <= 1'b0;
      r_rf_writereg <= 1'b0;
      r_rf_regdest  <= 5'd0;
      r_rf_wbvalue  <= 32'd0;
    end else begin
      r_rd_ptr      <= r_rd_ptr + PTR_W'(w_pop);
      r_wr_ptr      <= w_x_ptr + PTR_W'(w_enq_x);
      r_count       <= w_count_next;
      r_overflow    <= r_overflow || w_drop;
      r_rf_writereg <= w_out_valid;
      r_rf_regdest  <= w_out_dest;
      r_rf_wbvalue  <= w_out_val;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      if (w_enq_y) begin
        r_mem_dest[r_wr_ptr] <= y_wb_regdest;
        r_mem_val[r_wr_ptr]  <= y_wb_wbvalue;
      end
      if (w_enq_x) begin
        r_mem_dest[w_x_ptr] <= x_wb_regdest;
        r_mem_val[w_x_ptr]  <= x_wb_wbvalue;
      end
    end
  end

  assign wb_rf_writereg = r_rf_writereg;
  assign wb_rf_regdest  = r_rf_regdest;
  assign wb_rf_wbvalue  = r_rf_wbvalue;
  assign wb_count       = r_count;
  assign wb_overflow    = r_overflow;
  assign wb_is_stall    = (32'(r_count) >= STALL_TH);

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed self-checking bench for writeback_arbiter.
module tb_writeback_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  x_regdest = '0;
  logic        x_writereg = 1'b0;
  logic [31:0] x_wbvalue = '0;
  logic [4:0]  y_regdest = '0;
  logic        y_writereg = 1'b0;
  logic [31:0] y_wbvalue = '0;
  logic [4:0]  rf_regdest;
  logic        rf_writereg;
  logic [31:0] rf_wbvalue;
  logic        is_stall;
  logic        overflow;
  logic [3:0]  count;

  int n_checks = 0;
  int n_errors = 0;

  writeback_arbiter #(.DEPTH(8), .STALL_TH(3)) dut (
    .clock          (clock),
    .reset          (reset),
    .x_wb_regdest   (x_regdest),
    .x_wb_writereg  (x_writereg),
    .x_wb_wbvalue   (x_wbvalue),
    .y_wb_regdest   (y_regdest),
    .y_wb_writereg  (y_writereg),
    .y_wb_wbvalue   (y_wbvalue),
    .wb_rf_regdest  (rf_regdest),
    .wb_rf_writereg (rf_writereg),
    .wb_rf_wbvalue  (rf_wbvalue),
    .wb_is_stall    (is_stall),
    .wb_overflow    (overflow),
    .wb_count       (count)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    x_writereg = 1'b0; x_regdest = '0; x_wbvalue = '0;
    y_writereg = 1'b0; y_regdest = '0; y_wbvalue = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    x_writereg = 1'b1; x_regdest = 5'd6; x_wbvalue = 32'h66;
    y_writereg = 1'b1; y_regdest = 5'd7; y_wbvalue = 32'h77;
    tick(); tick();
    idle_inputs();
    reset = 1'b0;
    n_checks++;
    if ({rf_writereg, rf_regdest, rf_wbvalue} !== 38'd0) begin
      $display("FAIL reset_rf: got we=%0b rd=%0d val=%h, want 0/0/0", rf_writereg, rf_regdest,
               rf_wbvalue);
      n_errors++;
    end
    n_checks++;
    if (count !== 4'd0 || is_stall !== 1'b0 || overflow !== 1'b0) begin
      $display("FAIL reset_status: got count=%0d stall=%0b ovf=%0b, want 0/0/0", count, is_stall,
               overflow);
      n_errors++;
    end
    tick();
    n_checks++;
    if (rf_writereg !== 1'b0 || count !== 4'd0) begin
      $display("FAIL reset_inputs_ignored: got we=%0b count=%0d, want 0/0", rf_writereg, count);
      n_errors++;
    end
  endtask

  task automatic test_single_x();
    do_reset();
    x_writereg = 1'b1; x_regdest = 5'd5; x_wbvalue = 32'h11;
    tick();
    idle_inputs();
    n_checks++;
    if (rf_writereg !== 1'b1 || rf_regdest !== 5'd5 || rf_wbvalue !== 32'h11 || count !== 4'd0)
    begin
      $display("FAIL single_x_c1: got we=%0b rd=%0d val=%h cnt=%0d, want 1/5/11/0", rf_writereg,
               rf_regdest, rf_wbvalue, count);
      n_errors++;
    end
    tick();
    n_checks++;
    if (rf_writereg !== 1'b0 || rf_regdest !== 5'd5 || rf_wbvalue !== 32'h11 || count !== 4'd0)
    begin
      $display("FAIL single_x_c2: got we=%0b rd=%0d val=%h cnt=%0d, want 0/5/11/0 (held)",
               rf_writereg, rf_regdest, rf_wbvalue, count);
      n_errors++;
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    y_writereg = 1'b1; y_regdest = 5'd3; y_wbvalue = 32'hA;
    x_writereg = 1'b1; x_regdest = 5'd4; x_wbvalue = 32'hB;
    tick();
    idle_inputs();
    n_checks++;
    if (rf_writereg !== 1'b1 || rf_regdest !== 5'd3 || rf_wbvalue !== 32'hA || count !== 4'd1)
    begin
      $display("FAIL simul_c1: got we=%0b rd=%0d val=%h cnt=%0d, want 1/3/a/1", rf_writereg,
               rf_regdest, rf_wbvalue, count);
      n_errors++;
    end
    tick();
    n_checks++;
    if (rf_writereg !== 1'b1 || rf_regdest !== 5'd4 || rf_wbvalue !== 32'hB || count !== 4'd0)
    begin
      $display("FAIL simul_c2: got we=%0b rd=%0d val=%h cnt=%0d, want 1/4/b/0", rf_writereg,
               rf_regdest, rf_wbvalue, count);
      n_errors++;
    end
  endtask

  task automatic test_zero_filter();
    do_reset();
    x_writereg = 1'b1; x_regdest = 5'd0; x_wbvalue = 32'hFF;
    tick();
    n_checks++;
    if (rf_writereg !== 1'b0 || count !== 4'd0 || overflow !== 1'b0) begin
      $display("FAIL zero_reg: got we=%0b cnt=%0d ovf=%0b, want 0/0/0", rf_writereg, count,
               overflow);
      n_errors++;
    end
    x_writereg = 1'b0; x_regdest = 5'd7; x_wbvalue = 32'h77;
    y_writereg = 1'b0; y_regdest = 5'd8; y_wbvalue = 32'h88;
    tick();
    idle_inputs();
    n_checks++;
    if (rf_writereg !== 1'b0 || count !== 4'd0) begin
      $display("FAIL no_writereg: got we=%0b cnt=%0d, want 0/0", rf_writereg, count);
      n_errors++;
    end
  endtask

  // Y_i -> r(8+i)=A0+i, X_i -> r(16+i)=B0+i; retirement order Y0,X0,Y1,X1,...
  task automatic test_stall_threshold();
    logic [4:0]  e_dest;
    logic [31:0] e_val;
    logic [3:0]  e_cnt;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      if (i < 4) begin
        y_writereg = 1'b1; y_regdest = 5'(8 + i);  y_wbvalue = 32'hA0 + 32'(i);
        x_writereg = 1'b1; x_regdest = 5'(16 + i); x_wbvalue = 32'hB0 + 32'(i);
      end else begin
        idle_inputs();
      end
      tick();
      e_dest = (i % 2 == 0) ? 5'(8 + i / 2) : 5'(16 + i / 2);
      e_val  = (i % 2 == 0) ? 32'hA0 + 32'(i / 2) : 32'hB0 + 32'(i / 2);
      e_cnt  = (i < 4) ? 4'(i + 1) : 4'(7 - i);
      n_checks++;
      if (rf_writereg !== 1'b1 || rf_regdest !== e_dest || rf_wbvalue !== e_val) begin
        $display("FAIL stall_order[%0d]: got we=%0b rd=%0d val=%h, want 1/%0d/%h", i,
                 rf_writereg, rf_regdest, rf_wbvalue, e_dest, e_val);
        n_errors++;
      end
      n_checks++;
      if (count !== e_cnt || is_stall !== (e_cnt >= 4'd3)) begin
        $display("FAIL stall_count[%0d]: got cnt=%0d stall=%0b, want %0d/%0b", i, count,
                 is_stall, e_cnt, (e_cnt >= 4'd3));
        n_errors++;
      end
    end
    tick();
    n_checks++;
    if (rf_writereg !== 1'b0 || overflow !== 1'b0) begin
      $display("FAIL stall_drained: got we=%0b ovf=%0b, want 0/0", rf_writereg, overflow);
      n_errors++;
    end
  endtask

  // 10 cycles of dual input: X8 and X9 dropped, 18 results retire in order.
  task automatic test_overflow();
    logic [4:0]  e_dest;
    logic [31:0] e_val;
    logic [3:0]  e_cnt;
    do_reset();
    for (int i = 0; i < 18; i++) begin
      if (i < 10) begin
        y_writereg = 1'b1; y_regdest = 5'(8 + i);  y_wbvalue = 32'hA0 + 32'(i);
        x_writereg = 1'b1; x_regdest = 5'(16 + i); x_wbvalue = 32'hB0 + 32'(i);
      end else begin
        idle_inputs();
      end
      tick();
      if (i < 16) begin
        e_dest = (i % 2 == 0) ? 5'(8 + i / 2) : 5'(16 + i / 2);
        e_val  = (i % 2 == 0) ? 32'hA0 + 32'(i / 2) : 32'hB0 + 32'(i / 2);
      end else begin
        e_dest = 5'(8 + i - 8);
        e_val  = 32'hA0 + 32'(i - 8);
      end
      e_cnt = (i < 10) ? ((i < 7) ? 4'(i + 1) : 4'd8) : 4'(17 - i);
      n_checks++;
      if (rf_writereg !== 1'b1 || rf_regdest !== e_dest || rf_wbvalue !== e_val) begin
        $display("FAIL ovf_order[%0d]: got we=%0b rd=%0d val=%h, want 1/%0d/%h", i, rf_writereg,
                 rf_regdest, rf_wbvalue, e_dest, e_val);
        n_errors++;
      end
      n_checks++;
      if (count !== e_cnt || overflow !== (i >= 8)) begin
        $display("FAIL ovf_status[%0d]: got cnt=%0d ovf=%0b, want %0d/%0b", i, count, overflow,
                 e_cnt, (i >= 8));
        n_errors++;
      end
    end
    tick();
    n_checks++;
    if (rf_writereg !== 1'b0 || overflow !== 1'b1 || count !== 4'd0) begin
      $display("FAIL ovf_sticky: got we=%0b ovf=%0b cnt=%0d, want 0/1/0", rf_writereg, overflow,
               count);
      n_errors++;
    end
  endtask

  task automatic test_reset_mid_drain();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      y_writereg = 1'b1; y_regdest = 5'(1 + i);  y_wbvalue = 32'h300 + 32'(i);
      x_writereg = 1'b1; x_regdest = 5'(10 + i); x_wbvalue = 32'h400 + 32'(i);
      tick();
    end
    idle_inputs();
    n_checks++;
    if (count !== 4'd5 || is_stall !== 1'b1) begin
      $display("FAIL mid_pre: got cnt=%0d stall=%0b, want 5/1", count, is_stall);
      n_errors++;
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++;
    if (rf_writereg !== 1'b0 || count !== 4'd0 || is_stall !== 1'b0 || overflow !== 1'b0) begin
      $display("FAIL mid_reset: got we=%0b cnt=%0d stall=%0b ovf=%0b, want 0/0/0/0",
               rf_writereg, count, is_stall, overflow);
      n_errors++;
    end
    x_writereg = 1'b1; x_regdest = 5'd9; x_wbvalue = 32'h1;
    tick();
    idle_inputs();
    n_checks++;
    if (rf_writereg !== 1'b1 || rf_regdest !== 5'd9 || rf_wbvalue !== 32'h1 || count !== 4'd0)
    begin
      $display("FAIL mid_after: got we=%0b rd=%0d val=%h cnt=%0d, want 1/9/1/0", rf_writereg,
               rf_regdest, rf_wbvalue, count);
      n_errors++;
    end
    tick();
    n_checks++;
    if (rf_writereg !== 1'b0) begin
      $display("FAIL mid_stale: got we=%0b, want 0", rf_writereg);
      n_errors++;
    end
  endtask

  initial begin
    test_reset();
    test_single_x();
    test_simultaneous();
    test_zero_filter();
    test_stall_threshold();
    test_overflow();
    test_reset_mid_drain();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
